// File: rtl/cute_lock_state_gate.sv
// Time-windowed key gate owning the present-state register of a locked host FSM.
// Define CUTE_LOCK_LOCKOUT_EN to add consecutive-failure lockout.
module cute_lock_state_gate #(
    parameter int KEY_W       = 12,
    parameter int STATE_W     = 6,
    parameter int NUM_KEYS    = 4,
    parameter int WINDOW_LEN  = 9,
    parameter logic [NUM_KEYS*KEY_W-1:0] KEYS =
        {12'h455, 12'h892, 12'hAE9, 12'h981},
    parameter logic [NUM_KEYS*STATE_W-1:0] TRAPS =
        {6'd29, 6'd9, 6'd35, 6'd27},
    parameter int RESET_STATE = 1,
    parameter int MAX_FAILS   = 3,
    localparam int WIN_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int CNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [KEY_W-1:0]   keyinput,
    input  logic [STATE_W-1:0] nx_state,
    output logic [STATE_W-1:0] pr_state,
    output logic [WIN_W-1:0]   win_idx,
    output logic               key_ok,
    output logic               locked
);

    // TRAPS entries are STATE_W wide by construction; only RESET_STATE can overflow.
    if (RESET_STATE < 0 || RESET_STATE > (2**STATE_W) - 1) begin : g_bad_reset
        $error("RESET_STATE does not fit in STATE_W bits");
    end
    if (NUM_KEYS < 1 || WINDOW_LEN < 1 || MAX_FAILS < 1) begin : g_bad_param
        $error("NUM_KEYS, WINDOW_LEN and MAX_FAILS must be >= 1");
    end

    logic [KEY_W-1:0]   w_keys  [NUM_KEYS];
    logic [STATE_W-1:0] w_traps [NUM_KEYS];

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_tab
        assign w_keys[g]  = KEYS[g*KEY_W +: KEY_W];
        assign w_traps[g] = TRAPS[g*STATE_W +: STATE_W];
    end

    logic [STATE_W-1:0] r_pr_state, w_pr_nx;
    logic [WIN_W-1:0]   r_win_idx, w_win_nx;
    logic [CNT_W-1:0]   r_cyc_cnt, w_cyc_nx;
    logic               r_key_ok, w_ok_nx;
    logic               w_match;
    logic               w_locked_now;
    logic               w_pass;

    assign w_match = (keyinput == w_keys[r_win_idx]);
    assign w_pass  = w_match & ~w_locked_now;

`ifdef CUTE_LOCK_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    logic [FAIL_W-1:0] r_fail_cnt, w_fail_nx;
    logic              r_locked, w_locked_nx;

    assign w_locked_now = r_locked;

    always_comb begin
        w_fail_nx   = r_fail_cnt;
        w_locked_nx = r_locked;
        if (en) begin
            if (w_match) begin
                w_fail_nx = '0;
            end else if (r_fail_cnt != FAIL_W'(MAX_FAILS)) begin
                w_fail_nx = r_fail_cnt + 1'b1;
            end
            if (!w_match && w_fail_nx == FAIL_W'(MAX_FAILS)) begin
                w_locked_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_fail_cnt <= w_fail_nx;
            r_locked   <= w_locked_nx;
        end
    end

    assign locked = r_locked;
`else
    assign w_locked_now = 1'b0;
    assign locked       = 1'b0;
`endif

    always_comb begin
        w_pr_nx  = r_pr_state;
        w_ok_nx  = r_key_ok;
        w_cyc_nx = r_cyc_cnt;
        w_win_nx = r_win_idx;
        if (en) begin
            w_pr_nx = w_pass ? nx_state : w_traps[r_win_idx];
            w_ok_nx = w_pass;
            if (r_cyc_cnt == CNT_W'(WINDOW_LEN - 1)) begin
                w_cyc_nx = '0;
                if (r_win_idx == WIN_W'(NUM_KEYS - 1)) begin
                    w_win_nx = '0;
                end else begin
                    w_win_nx = r_win_idx + 1'b1;
                end
            end else begin
                w_cyc_nx = r_cyc_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pr_state <= STATE_W'(RESET_STATE);
            r_win_idx  <= '0;
            r_cyc_cnt  <= '0;
            r_key_ok   <= 1'b0;
        end else begin
            r_pr_state <= w_pr_nx;
            r_win_idx  <= w_win_nx;
            r_cyc_cnt  <= w_cyc_nx;
            r_key_ok   <= w_ok_nx;
        end
    end

    assign pr_state = r_pr_state;
    assign win_idx  = r_win_idx;
    assign key_ok   = r_key_ok;

endmodule
